serial_cmp_seq: RTL and testbench

- Sequential controller that performs a WIDTH-bit unsigned magnitude compare one bit per clock, MSB first.
- Reuses a single bit-slice (greater-so-far / equal-so-far) state pair instead of a WIDTH-deep combinational chain.
- Accepts an operand pair with a start/busy/done handshake and reports gt/eq when the compare completes.
- Optional early termination once the first differing bit has been found.

---
 rtl/serial_cmp_seq.sv | 141 ++++++++++++++
 tb/tb_serial_cmp_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_seq.sv
// serial_cmp_seq: WIDTH-bit unsigned magnitude comparator that walks the
// operands one bit per clock, MSB first. A single greater-so-far /
// equal-so-far pair replaces a WIDTH-deep combinational chain. Operands are
// latched on start; done pulses for one cycle with gt/eq/steps valid.
module serial_cmp_seq #(
    parameter int WIDTH      = 6,
    parameter int EARLY_EXIT = 1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic [CW-1:0]    steps
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic [IW-1:0]    idx_reg;
    logic             gi_reg;
    logic             ei_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] bit_sel;
    logic             x_bit;
    logic             y_bit;
    logic             bit_diff;
    logic             gi_step;
    logic             ei_step;
    logic             last_step;
    logic             load;
    logic             step;

    // One-hot decode of the current bit position; keeps the bit pick a
    // plain AND-OR and avoids out-of-range indexing when WIDTH is not 2^n.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign bit_sel[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

    assign x_bit    = |(ra_reg & bit_sel);
    assign y_bit    = |(rb_reg & bit_sel);
    assign bit_diff = x_bit ^ y_bit;

    // Bit-slice update: the first differing bit (from the MSB) decides the
    // result; after that greater/equal are frozen.
    always_comb begin
        gi_step   = gi_reg;
        ei_step   = ei_reg;
        last_step = (idx_reg == '0);
        if (ei_reg && bit_diff) begin
            gi_step = x_bit & ~y_bit;
            ei_step = 1'b0;
        end
        if ((EARLY_EXIT != 0) && bit_diff) begin
            last_step = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new start directly so back-to-back
    // compares need no idle bubble.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_step ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and control decode from the current state.
    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
        step = (state_reg == RUN);
        load = (state_reg != RUN) && start;
    end

    // Operand latch, bit walk and result registers. Results only change on
    // the final step, so they hold between compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_reg  <= '0;
            rb_reg  <= '0;
            idx_reg <= '0;
            gi_reg  <= 1'b0;
            ei_reg  <= 1'b0;
            cnt_reg <= '0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            steps   <= '0;
        end else if (load) begin
            ra_reg  <= a;
            rb_reg  <= b;
            idx_reg <= IW'(WIDTH - 1);
            gi_reg  <= 1'b0;
            ei_reg  <= 1'b1;
            cnt_reg <= '0;
        end else if (step) begin
            gi_reg  <= gi_step;
            ei_reg  <= ei_step;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_step) begin
                gt    <= gi_step;
                eq    <= ei_step;
                steps <= cnt_reg + CW'(1);
            end else begin
                idx_reg <= idx_reg - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_cmp_seq.sv
// Bench for serial_cmp_seq: one instance with early exit, one without, both
// fed the same stimulus and checked every cycle against a transaction-level
// model (result from plain arithmetic, latency from the first-difference
// position), plus directed cases with literal expectations.
module tb_serial_cmp_seq;

    localparam int W  = 6;
    localparam int CW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [1:0]          d_busy, d_done, d_gt, d_eq;
    logic [1:0][CW-1:0]  d_steps;

    int compared = 0;
    int mismatched = 0;
    bit chk_en = 1'b0;
    int done0_cnt = 0;

    serial_cmp_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(d_busy[0]), .done(d_done[0]), .gt(d_gt[0]), .eq(d_eq[0]),
        .steps(d_steps[0])
    );

    serial_cmp_seq #(.WIDTH(W), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(d_busy[1]), .done(d_done[1]), .gt(d_gt[1]), .eq(d_eq[1]),
        .steps(d_steps[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare length: WIDTH unless early exit finds a difference, in which
    // case it is the 1-based position of the first differing bit from the MSB.
    function automatic int n_steps(input int av, input int bv, input int ee);
        int x;
        x = av ^ bv;
        if (x == 0 || ee == 0) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (((x >> i) & 1) != 0) return W - i;
        end
        return W;
    endfunction

    // Transaction model per instance: remaining-cycle countdown and the
    // result computed up front at the accept edge.
    logic [1:0] m_busy, m_done, m_gt, m_eq, p_gt, p_eq;
    int         m_steps [2];
    int         p_steps [2];
    int         m_rem   [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= '0; m_done <= '0; m_gt <= '0; m_eq <= '0;
            p_gt <= '0; p_eq <= '0;
            for (int k = 0; k < 2; k++) begin
                m_steps[k] <= 0; p_steps[k] <= 0; m_rem[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k]) begin
                    if (m_rem[k] == 1) begin
                        m_busy[k]  <= 1'b0;
                        m_done[k]  <= 1'b1;
                        m_gt[k]    <= p_gt[k];
                        m_eq[k]    <= p_eq[k];
                        m_steps[k] <= p_steps[k];
                    end else begin
                        m_rem[k]  <= m_rem[k] - 1;
                        m_done[k] <= 1'b0;
                    end
                end else begin
                    m_done[k] <= 1'b0;
                    if (start) begin
                        m_busy[k]  <= 1'b1;
                        m_rem[k]   <= n_steps(int'(a), int'(b), (k == 0) ? 1 : 0);
                        p_steps[k] <= n_steps(int'(a), int'(b), (k == 0) ? 1 : 0);
                        p_gt[k]    <= (a > b);
                        p_eq[k]    <= (a == b);
                    end
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k),  int'(d_busy[k]),  int'(m_busy[k]));
                chk($sformatf("done%0d", k),  int'(d_done[k]),  int'(m_done[k]));
                chk($sformatf("gt%0d", k),    int'(d_gt[k]),    int'(m_gt[k]));
                chk($sformatf("eq%0d", k),    int'(d_eq[k]),    int'(m_eq[k]));
                chk($sformatf("steps%0d", k), int'(d_steps[k]), m_steps[k]);
                chk($sformatf("excl%0d", k),  int'(d_gt[k] & d_eq[k]), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (d_done[0]) done0_cnt++;
    end

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_busy%0d", tag, k),  int'(d_busy[k]),  0);
            chk($sformatf("%s_done%0d", tag, k),  int'(d_done[k]),  0);
            chk($sformatf("%s_gt%0d", tag, k),    int'(d_gt[k]),    0);
            chk($sformatf("%s_eq%0d", tag, k),    int'(d_eq[k]),    0);
            chk($sformatf("%s_steps%0d", tag, k), int'(d_steps[k]), 0);
        end
    endtask

    // Wait (bounded) for both instances to pulse done and pin the result
    // to literal values; exp_bc < 0 skips the busy-length check.
    task automatic wait_done(input string tag, input int eg, input int ee,
                             input int s0, input int s1, input int exp_bc);
        bit got0, got1;
        int bc;
        got0 = 0; got1 = 0; bc = 0;
        for (int c = 0; c < 24 && !(got0 && got1); c++) begin
            if (d_busy[0]) bc++;
            if (d_done[0] && !got0) begin
                got0 = 1;
                chk({tag, "_gt0"}, int'(d_gt[0]), eg);
                chk({tag, "_eq0"}, int'(d_eq[0]), ee);
                chk({tag, "_steps0"}, int'(d_steps[0]), s0);
                if (exp_bc >= 0) chk({tag, "_busylen0"}, bc, exp_bc);
            end
            if (d_done[1] && !got1) begin
                got1 = 1;
                chk({tag, "_gt1"}, int'(d_gt[1]), eg);
                chk({tag, "_eq1"}, int'(d_eq[1]), ee);
                chk({tag, "_steps1"}, int'(d_steps[1]), s1);
            end
            @(negedge clk);
        end
        if (!(got0 && got1)) chk({tag, "_timeout"}, 0, 1);
        $display("txn %s: gt0=%0d eq0=%0d steps0=%0d steps1=%0d", tag,
                 d_gt[0], d_eq[0], d_steps[0], d_steps[1]);
    endtask

    task automatic run_pair(input string tag, input int av, input int bv, input int eg,
                            input int ee, input int s0, input int s1);
        @(negedge clk);
        a = W'(av); b = W'(bv); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, eg, ee, s0, s1, s0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pi;
        int base;
        // Reset state.
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        run_pair("eq45", 45, 45, 0, 1, 6, 6);
        run_pair("gt32_31", 32, 31, 1, 0, 1, 6);
        run_pair("lt6_7", 6, 7, 0, 0, 6, 6);
        run_pair("gt7_6", 7, 6, 1, 0, 6, 6);

        // Operands and start wiggle during busy: only the latched pair counts.
        @(negedge clk);
        a = W'(50); b = W'(50); start = 1'b1;
        @(negedge clk);
        repeat (3) begin
            a = W'($urandom); b = W'($urandom); start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("busy_chg", 0, 1, 6, 6, -1);

        // Reset in the 3rd RUN cycle abandons the compare.
        @(negedge clk);
        a = W'(13); b = W'(13); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("midrst_nodone", int'(d_done[0] | d_done[1]), 0);
            @(negedge clk);
        end
        run_pair("post_rst", 32, 31, 1, 0, 1, 6);

        // Exhaustive sweep, start held high, new pair whenever dut0 is free.
        base = done0_cnt;
        pi = 0;
        while (pi < 4096) begin
            @(negedge clk);
            if (!m_busy[0]) begin
                a = W'(pi >> W); b = W'(pi); start = 1'b1;
                pi++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && (done0_cnt - base) < 4096; c++) @(negedge clk);
        chk("sweep_done_count", done0_cnt - base, 4096);
        $display("txn sweep: done pulses=%0d", done0_cnt - base);
        repeat (10) @(negedge clk);

        // Random traffic.
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
